switch_out_arbiter: RTL and testbench
=====================================

# switch_out_arbiter

Per-output-port arbiter for the 4x4 switch. Each output port has four input queues (one per ingress port) holding 33-bit words, bit 32 marking end-of-packet (EOP). The block grants one queue at a time in round-robin order, pops a whole packet from it into a single registered output stage with valid/ready backpressure, then re-arbitrates. One instance sits between the four queues feeding an output port and that port's egress logic.

## Interface
- `NUM_IN`, 4: number of input queues; fixed at 4 in this design.
- `DATA_W`, 33: queue word width; bit `DATA_W-1` is EOP.
- `MAX_PKT`, 16: word limit per grant; used only when `ARB_PKT_LIMIT_EN` is defined.
- `clk`, input, 1: single clock; all state on rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `q_empty`, input, 4: per-queue empty flags; bit i for queue i.
- `q_rd_data`, input, 4*33: head word of each queue, shown combinationally (first-word-fall-through); queue i at `[33*i+32 : 33*i]`.
- `q_rd_en`, output, 4: one-hot pop strobe; pops the head of queue i at the clock edge.
- `out_data`, output, 33: registered output word.
- `out_valid`, output, 1: `out_data` holds a word.
- `out_ready`, input, 1: consumer accepts the word when `out_valid && out_ready`.
- `grant`, output, 2: index of the currently granted queue.
- `busy`, output, 1: a grant is active (state GRANT).

## Operation
- States: IDLE and GRANT. Registers: `grant`, `rr_ptr` (2 bits, last granted), output word and valid bit, and the word counter when the limit is enabled.
- IDLE: if any `q_empty[i]==0`, select the first non-empty queue searching `rr_ptr+1, rr_ptr+2, ...` modulo 4. Register it in `grant` and `rr_ptr`, then go to GRANT. If all queues are empty, stay in IDLE.
- GRANT: compute `load = !q_empty[grant] && (!out_valid || out_ready)`. When `load` is high, assert `q_rd_en[grant]` and latch `q_rd_data` of the granted queue into `out_data`. When `load` is low, hold.
- If the popped word has bit 32 set, go to IDLE on that edge.
- An empty granted queue mid-packet stalls the grant; the block never switches inputs mid-packet.
- `q_rd_en` is zero in IDLE, zero for any empty queue, and at most one bit is set.
- Output stage: set `out_valid` on `load`. Clear it when `out_valid && out_ready && !load`. Simultaneous accept and load replaces the word with no bubble.
- Reset values: `out_valid=0`, `out_data=0`, `q_rd_en=0`, `grant=0`, `rr_ptr=3` (so queue 0 wins first), `busy=0`, state IDLE.
- Reset mid-packet aborts the grant. The word held in the output register is dropped. The queue contents are the queue's own concern.

## Timing
- Arbitration costs 1 cycle. With a queue non-empty at cycle 0 and the block idle: `grant` is registered at edge 1, the first pop happens at edge 2, and `out_valid` is high in cycle 2.
- Steady state is one word per cycle while `out_ready=1` and the queue is non-empty.
- Each packet costs one idle cycle between packets for re-arbitration.
- `q_rd_en` is combinational from state, `q_empty`, `out_valid` and `out_ready`; there is no registered-read latency.

## Configuration
- `ARB_PKT_LIMIT_EN` defined:
  - A 5-bit counter counts pops in the current grant and clears on entry to GRANT.
  - The grant releases to IDLE on EOP or on the `MAX_PKT`-th pop, whichever comes first.
  - Fairness is guaranteed against runaway packets that never present EOP.
- `ARB_PKT_LIMIT_EN` undefined: no counter; release happens on EOP only.

## Structure
- Shared package `switch_pkg`: `DATA_W`, `NUM_IN`, the EOP bit index, and the state enum (`ST_IDLE`, `ST_GRANT`). The 4x4 top and the queue use the same constants.
- Sub-module `rr_pick`: purely combinational, inputs 4-bit request and 2-bit pointer, outputs 2-bit index and a valid flag. It is reusable by the other output ports.

## Test plan
- Single packet: queue 1 holds words 25, 78, 738 (EOP on 738), `out_ready=1`. Expected: grant=1 in cycle 1, outputs 25/78/738 in cycles 2–4, `busy` returns to 0.
- Round-robin: all four queues hold one single-word EOP packet each. Expected: service order 0,1,2,3, then queue 0 again after a refill; each grant separated by one idle cycle.
- Backpressure: `out_ready` low for 3 cycles mid-packet. Expected: `out_data` held stable, `q_rd_en` low, no word lost or duplicated, throughput resumes at 1 word/cycle.
- Starvation mid-packet: queue 2 empties before EOP while queue 3 is non-empty. Expected: grant stays at 2 until queue 2 refills and EOP pops; queue 3 is not served earlier.
- Reset mid-packet: `rst` pulled low during the second word. Expected: outputs go to reset values immediately, asynchronously; after release, arbitration restarts with queue 0 first.
- With `ARB_PKT_LIMIT_EN` and `MAX_PKT=4`: queue 0 holds 6 words with no EOP and queue 1 holds a 1-word packet. Expected: 4 words from queue 0, then queue 1, then the remaining 2 words from queue 0.

Source files
------------

// File: rtl/switch_pkg.sv
// Constants and state encoding shared by the 4x4 switch top, its queues and the
// per-output-port arbiters.
package switch_pkg;

  localparam int NUM_IN  = 4;
  localparam int DATA_W  = 33;
  localparam int EOP_BIT = DATA_W - 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/switch_out_arbiter_if.sv
// Queue-side and egress-side signals of one output-port arbiter.
// The master modport is the arbiter; the slave modport is the queues plus egress logic.
interface switch_out_arbiter_if;
  import switch_pkg::*;

  logic [NUM_IN-1:0]        q_empty;
  logic [NUM_IN*DATA_W-1:0] q_rd_data;
  logic [NUM_IN-1:0]        q_rd_en;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               grant;
  logic                     busy;

  modport master (
    input  q_empty, q_rd_data, out_ready,
    output q_rd_en, out_data, out_valid, grant, busy
  );

  modport slave (
    output q_empty, q_rd_data, out_ready,
    input  q_rd_en, out_data, out_valid, grant, busy
  );

endinterface

// File: rtl/switch_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo 4.
// Shared by every output port of the switch.
module rr_pick
  import switch_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [1:0]        ptr,
  output logic [1:0]        idx,
  output logic              vld
);

  // Walk from the lowest priority (ptr itself) up to ptr+1 so the nearest wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = NUM_IN; k >= 1; k--) begin
      if (req[ptr + 2'(k)]) begin
        idx = ptr + 2'(k);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_out_arbiter.sv
// Per-output-port packet arbiter: round-robin grant, whole-packet pop, one registered
// output stage with valid/ready. Define ARB_PKT_LIMIT_EN to cap each grant at MAX_PKT words.
module switch_out_arbiter
  import switch_pkg::*;
`ifdef ARB_PKT_LIMIT_EN
  #(parameter int MAX_PKT = 16)
`endif
(
  input  logic                 clk,
  input  logic                 rst,
  switch_out_arbiter_if.master bus
);

  arb_state_t        state_q, state_d;
  logic [1:0]        grant_q;
  logic [1:0]        rr_ptr_q;
  logic [DATA_W-1:0] out_data_p0;
  logic              vld_p0;

  logic [DATA_W-1:0] heads [NUM_IN];
  logic [DATA_W-1:0] head;
  logic [NUM_IN-1:0] rd_en;
  logic [1:0]        pick_idx;
  logic              pick_vld;
  logic              load;
  logic              pkt_done;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_head
    assign heads[i] = bus.q_rd_data[DATA_W*i +: DATA_W];
  end
  assign head = heads[grant_q];

  rr_pick u_rr_pick (
    .req (~bus.q_empty),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

`ifdef ARB_PKT_LIMIT_EN
  logic [4:0] pop_cnt_p0;

  assign pkt_done = head[EOP_BIT] || (pop_cnt_p0 == 5'(MAX_PKT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_cnt_p0 <= '0;
    end else if (state_q == ST_IDLE) begin
      pop_cnt_p0 <= '0;
    end else if (load) begin
      pop_cnt_p0 <= pop_cnt_p0 + 5'd1;
    end
  end
`else
  assign pkt_done = head[EOP_BIT];
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    rd_en   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        load = !bus.q_empty[grant_q] && (!vld_p0 || bus.out_ready);
        if (load) begin
          rd_en[grant_q] = 1'b1;
          if (pkt_done) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: popped head word lands in the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= 2'd3;
      out_data_p0 <= '0;
      vld_p0      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pick_vld) begin
        grant_q  <= pick_idx;
        rr_ptr_q <= pick_idx;
      end
      if (load) begin
        out_data_p0 <= head;
        vld_p0      <= 1'b1;
      end else if (vld_p0 && bus.out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign bus.q_rd_en   = rd_en;
  assign bus.out_data  = out_data_p0;
  assign bus.out_valid = vld_p0;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Bench for switch_out_arbiter: FWFT queue models, directed packets, scoreboard monitor.
`timescale 1ns/1ps
module tb_switch_out_arbiter;
  import switch_pkg::*;

  typedef logic [DATA_W-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  switch_out_arbiter_if bus();

`ifdef ARB_PKT_LIMIT_EN
  switch_out_arbiter #(.MAX_PKT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  switch_out_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  word_t      qm0[$], qm1[$], qm2[$], qm3[$];
  word_t      exp_q[$];
  logic [3:0] pend;

  function automatic word_t mid(input logic [31:0] v);
    return {1'b0, v};
  endfunction

  function automatic word_t eop(input logic [31:0] v);
    return {1'b1, v};
  endfunction

  task automatic push(input int q, input word_t w, input bit expect_it);
    case (q)
      0: qm0.push_back(w);
      1: qm1.push_back(w);
      2: qm2.push_back(w);
      default: qm3.push_back(w);
    endcase
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic refresh();
    logic [3:0]          e;
    logic [4*DATA_W-1:0] d;
    e = '1;
    d = '0;
    if (qm0.size() != 0) begin e[0] = 1'b0; d[0*DATA_W +: DATA_W] = qm0[0]; end
    if (qm1.size() != 0) begin e[1] = 1'b0; d[1*DATA_W +: DATA_W] = qm1[0]; end
    if (qm2.size() != 0) begin e[2] = 1'b0; d[2*DATA_W +: DATA_W] = qm2[0]; end
    if (qm3.size() != 0) begin e[3] = 1'b0; d[3*DATA_W +: DATA_W] = qm3[0]; end
    bus.q_empty   = e;
    bus.q_rd_data = d;
  endtask

  // One clock: capture pop strobes mid-cycle, pop after the edge, land at edge+1ns.
  task automatic step();
    word_t tmp;
    @(negedge clk);
    pend = bus.q_rd_en;
    @(posedge clk);
    #1;
    if (pend[0]) tmp = qm0.pop_front();
    if (pend[1]) tmp = qm1.pop_front();
    if (pend[2]) tmp = qm2.pop_front();
    if (pend[3]) tmp = qm3.pop_front();
    refresh();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor and protocol watch, sampled mid-cycle.
  word_t prev_data;
  logic  prev_hold = 1'b0;
  always @(negedge clk) begin
    word_t w;
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      checks++;
      if (!$onehot0(bus.q_rd_en) || ((bus.q_rd_en & bus.q_empty) != 4'b0) ||
          (!bus.busy && bus.q_rd_en != 4'b0)) begin
        errors++;
        $display("FAIL rd_en_protocol: q_rd_en=%b q_empty=%b busy=%b, expected legal strobe",
                 bus.q_rd_en, bus.q_empty, bus.busy);
      end
      if (prev_hold) begin
        checks++;
        if (!bus.out_valid || bus.out_data !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: valid=%b data=%0h, expected valid=1 data=%0h",
                   bus.out_valid, bus.out_data, prev_data);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %0h, expected no word", bus.out_data);
        end else begin
          w = exp_q.pop_front();
          if (bus.out_data !== w) begin
            errors++;
            $display("FAIL out_data: got %0h, expected %0h", bus.out_data, w);
          end
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.out_ready = 1'b1;
    pend = '0;
    refresh();
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_q_rd_en",   bus.q_rd_en,   0);
    chk("rst_grant",     bus.grant,     0);
    chk("rst_busy",      bus.busy,      0);
    step(); step();
    rst = 1'b1;
    step();

    // Single packet on queue 1
    push(1, mid(25), 1); push(1, mid(78), 1); push(1, eop(738), 1); refresh();
    step();
    chk("t1_grant_c1", bus.grant, 1);
    chk("t1_busy_c1", bus.busy, 1);
    chk("t1_valid_c1", bus.out_valid, 0);
    step(); chk("t1_valid_c2", bus.out_valid, 1); chk("t1_data_c2", bus.out_data, mid(25));
    step(); chk("t1_data_c3", bus.out_data, mid(78));
    step(); chk("t1_data_c4", bus.out_data, eop(738)); chk("t1_busy_c4", bus.busy, 0);
    wait_drain("t1", 20);
    step(); chk("t1_busy_end", bus.busy, 0); chk("t1_valid_end", bus.out_valid, 0);

    // Round robin from a fresh reset
    rst = 1'b0; step(); rst = 1'b1; step();
    for (int i = 0; i < 4; i++) push(i, eop(32'h100 + i), 1);
    refresh();
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t2_valid", bus.out_valid, (k % 2 == 0) ? 1 : 0);
      chk("t2_grant", bus.grant, (k - 1) / 2);
      if (k % 2 == 0) chk("t2_data", bus.out_data, eop(32'h100 + k/2 - 1));
    end
    wait_drain("t2", 20);
    step();
    push(2, eop(32'h202), 0); push(0, eop(32'h200), 0); refresh();
    exp_q.push_back(eop(32'h200)); exp_q.push_back(eop(32'h202));
    wait_drain("t2_refill", 20);
    step();

    // Backpressure mid-packet on queue 1
    for (int i = 1; i <= 4; i++) push(1, mid(32'h10 + i), 1);
    push(1, eop(32'h15), 1); refresh();
    step(); chk("t3_grant", bus.grant, 1);
    step(); chk("t3_data_c2", bus.out_data, mid(32'h11));
    step(); chk("t3_data_c3", bus.out_data, mid(32'h12));
    bus.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) step();
      chk("t3_stall_rd_en", bus.q_rd_en, 0);
      chk("t3_stall_data", bus.out_data, mid(32'h12));
      chk("t3_stall_valid", bus.out_valid, 1);
    end
    step();
    bus.out_ready = 1'b1;
    step(); chk("t3_data_c7", bus.out_data, mid(32'h13));
    step(); chk("t3_data_c8", bus.out_data, mid(32'h14));
    step(); chk("t3_data_c9", bus.out_data, eop(32'h15));
    wait_drain("t3", 20);
    step();

    // Granted queue 2 starves mid-packet while queue 3 waits
    push(2, mid(32'h21), 1); push(2, mid(32'h22), 1); push(3, eop(32'h31), 0); refresh();
    step(); chk("t4_grant_c1", bus.grant, 2);
    step(); step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_stall_grant", bus.grant, 2);
      chk("t4_stall_busy", bus.busy, 1);
      chk("t4_stall_rd_en", bus.q_rd_en, 0);
    end
    push(2, eop(32'h23), 1); refresh();
    exp_q.push_back(eop(32'h31));
    wait_drain("t4", 30);
    step();

    // Reset during the second word of a queue 0 packet
    push(0, mid(32'h41), 1); push(0, mid(32'h42), 0); push(0, eop(32'h43), 0); refresh();
    step();
    step(); chk("t5_data_c2", bus.out_data, mid(32'h41));
    step(); chk("t5_data_c3", bus.out_data, mid(32'h42));
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_data",  bus.out_data,  0);
    chk("t5_rst_rd_en", bus.q_rd_en,   0);
    chk("t5_rst_grant", bus.grant,     0);
    chk("t5_rst_busy",  bus.busy,      0);
    step();
    rst = 1'b1;
    push(1, eop(32'h51), 0); refresh();
    exp_q.push_back(eop(32'h43)); exp_q.push_back(eop(32'h51));
    step(); chk("t5_regrant", bus.grant, 0);
    wait_drain("t5", 20);
    step();

`ifdef ARB_PKT_LIMIT_EN
    // Runaway packet on queue 0 is cut after MAX_PKT=4 words
    for (int i = 1; i <= 6; i++) push(0, mid(32'h60 + i), 0);
    push(1, eop(32'h71), 0); refresh();
    for (int i = 1; i <= 4; i++) exp_q.push_back(mid(32'h60 + i));
    exp_q.push_back(eop(32'h71));
    exp_q.push_back(mid(32'h65)); exp_q.push_back(mid(32'h66));
    wait_drain("t6", 40);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
